// File: rtl/input_debounce_ctrl.sv
// input_debounce_ctrl
// Conditions NUM_CH asynchronous board inputs for the core clock domain.
// Each channel: 2-flop synchronizer -> debounce FSM (IDLE/SETTLE) that commits
// a level change only after STABLE_CYCLES consecutive agreeing samples.
// Outputs: debounced level, one-cycle rise/fall pulses, sticky event flags.
// Optional feature macro: DEBOUNCE_IRQ_EN (registered masked interrupt).
// Without the macro irq_o is tied low and irq_mask_i is ignored.

module input_debounce_ctrl #(
   parameter int NUM_CH        = 4,
   parameter int STABLE_CYCLES = 16,
   parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] async_in,
   output logic [NUM_CH-1:0] level_o,
   output logic [NUM_CH-1:0] rise_o,
   output logic [NUM_CH-1:0] fall_o,
   output logic [NUM_CH-1:0] evt_pending_o,
   input  logic [NUM_CH-1:0] evt_clr_i,
   input  logic [NUM_CH-1:0] irq_mask_i,
   output logic              irq_o
);

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } state_t;

   // Last count value before a commit; the counter never goes past it.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic [NUM_CH-1:0] w_evt;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic             r_sync0;
         logic             r_sync1;
         state_t           r_state;
         logic [CNT_W-1:0] r_cnt;
         logic             r_level;
         logic             r_rise;
         logic             r_fall;
         logic             r_evt;
         logic             w_diff;

         // Two-stage synchronizer, nothing between the stages.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_sync0 <= 1'b0;
               r_sync1 <= 1'b0;
            end else begin
               r_sync0 <= async_in[gi];
               r_sync1 <= r_sync0;
            end
         end

         assign w_diff = (r_sync1 != r_level);

         // Debounce FSM with registered level/pulse outputs and sticky event flag.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_level <= 1'b0;
               r_rise  <= 1'b0;
               r_fall  <= 1'b0;
               r_evt   <= 1'b0;
            end else begin
               r_rise <= 1'b0;
               r_fall <= 1'b0;
               // Clear first so a same-cycle commit below overrides it.
               if (evt_clr_i[gi]) begin
                  r_evt <= 1'b0;
               end
               case (r_state)
                  IDLE: begin
                     if (w_diff) begin
                        r_state <= SETTLE;
                        r_cnt   <= CNT_W'(1);
                     end else begin
                        r_cnt   <= '0;
                     end
                  end
                  SETTLE: begin
                     if (!w_diff) begin
                        // Glitch: sample agreed with current level again.
                        r_state <= IDLE;
                        r_cnt   <= '0;
                     end else if (r_cnt == CNT_MAX) begin
                        r_level <= r_sync1;
                        r_rise  <= r_sync1;
                        r_fall  <= ~r_sync1;
                        r_evt   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                     end else begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                     end
                  end
                  default: begin
                     r_state <= IDLE;
                     r_cnt   <= '0;
                  end
               endcase
            end
         end

         assign level_o[gi]       = r_level;
         assign rise_o[gi]        = r_rise;
         assign fall_o[gi]        = r_fall;
         assign evt_pending_o[gi] = r_evt;
         assign w_evt[gi]         = r_evt;
      end
   endgenerate

`ifdef DEBOUNCE_IRQ_EN
   logic r_irq;

   // Interrupt follows masked pending flags one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(w_evt & irq_mask_i);
      end
   end

   assign irq_o = r_irq;
`else
   logic w_unused_irq;

   assign w_unused_irq = ^{w_evt, irq_mask_i};
   assign irq_o        = 1'b0;
`endif

endmodule

// File: tb/tb_input_debounce_ctrl.sv
// Directed testbench for input_debounce_ctrl (NUM_CH=4, STABLE_CYCLES=8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_input_debounce_ctrl;

   localparam int NCH = 4;
   localparam int STB = 8;

   logic           clk;
   logic           rst;
   logic [NCH-1:0] async_in;
   logic [NCH-1:0] level_o;
   logic [NCH-1:0] rise_o;
   logic [NCH-1:0] fall_o;
   logic [NCH-1:0] evt_pending_o;
   logic [NCH-1:0] evt_clr_i;
   logic [NCH-1:0] irq_mask_i;
   logic           irq_o;

   int n_checks;
   int n_fail;
   int rise_cnt [NCH];

   input_debounce_ctrl #(
      .NUM_CH        (NCH),
      .STABLE_CYCLES (STB)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .async_in      (async_in),
      .level_o       (level_o),
      .rise_o        (rise_o),
      .fall_o        (fall_o),
      .evt_pending_o (evt_pending_o),
      .evt_clr_i     (evt_clr_i),
      .irq_mask_i    (irq_mask_i),
      .irq_o         (irq_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check, reports mismatches.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   // Advance n clock edges, sampling 1 unit after each edge and tallying rise pulses.
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         for (int c = 0; c < NCH; c++) begin
            rise_cnt[c] += int'(rise_o[c]);
         end
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      for (int c = 0; c < NCH; c++) rise_cnt[c] = 0;
      rst        = 1'b1;
      async_in   = '0;
      evt_clr_i  = '0;
      irq_mask_i = '0;
      step(2);
      check("reset_level", 32'(level_o), 32'h0);
      check("reset_rise",  32'(rise_o), 32'h0);
      check("reset_fall",  32'(fall_o), 32'h0);
      check("reset_evt",   32'(evt_pending_o), 32'h0);
      check("reset_irq",   32'(irq_o), 32'h0);
      rst = 1'b0;
      step(2);

`ifdef DEBOUNCE_IRQ_EN
      irq_mask_i = 4'b0010;
`endif

      // Channel 0 rise: level commits on the 10th edge after the change.
      async_in[0] = 1'b1;
      step(STB + 1);
      check("ch0_level_before", 32'(level_o), 32'h0);
      check("ch0_rise_before",  32'(rise_o), 32'h0);
      step(1);
      check("ch0_level_commit", 32'(level_o), 32'h1);
      check("ch0_rise_pulse",   32'(rise_o), 32'h1);
      check("ch0_fall_none",    32'(fall_o), 32'h0);
      check("ch0_evt",          32'(evt_pending_o), 32'h1);
      step(1);
      check("ch0_rise_gone",    32'(rise_o), 32'h0);
      check("ch0_level_hold",   32'(level_o), 32'h1);
      check("ch0_irq_masked",   32'(irq_o), 32'h0);

      // Channel 1 glitch: 5 cycles high is too short.
      async_in[1] = 1'b1;
      step(5);
      async_in[1] = 1'b0;
      step(20);
      check("glitch_level", 32'(level_o[1]), 32'h0);
      check("glitch_rises", 32'(rise_cnt[1]), 32'h0);
      check("glitch_evt",   32'(evt_pending_o), 32'h1);

      // Channel 2 bounce: toggle every 3 cycles for 30 cycles, then hold high.
      for (int seg = 0; seg < 10; seg++) begin
         async_in[2] = (seg % 2 == 0);
         step(3);
      end
      check("bounce_no_rise", 32'(rise_cnt[2]), 32'h0);
      async_in[2] = 1'b1;
      step(STB + 1);
      check("bounce_level_before", 32'(level_o[2]), 32'h0);
      step(1);
      check("bounce_rise_pulse", 32'(rise_o), 32'h4);
      check("bounce_level",      32'(level_o), 32'h5);
      step(5);
      check("bounce_one_rise",   32'(rise_cnt[2]), 32'h1);
      check("bounce_evt",        32'(evt_pending_o), 32'h5);

      // Collision: clear held on channel 0 while it commits a fall.
      evt_clr_i[0] = 1'b1;
      async_in[0]  = 1'b0;
      step(STB + 1);
      check("coll_evt_cleared", 32'(evt_pending_o[0]), 32'h0);
      check("coll_fall_before", 32'(fall_o), 32'h0);
      step(1);
      check("coll_fall_pulse",  32'(fall_o), 32'h1);
      check("coll_set_wins",    32'(evt_pending_o[0]), 32'h1);
      check("coll_level",       32'(level_o), 32'h4);
      step(1);
      check("coll_evt_reclear", 32'(evt_pending_o[0]), 32'h0);
      check("coll_fall_gone",   32'(fall_o), 32'h0);
      evt_clr_i = 4'b0100;
      step(1);
      check("clr_ch2_evt",      32'(evt_pending_o), 32'h0);
      evt_clr_i = '0;

`ifdef DEBOUNCE_IRQ_EN
      // Masked channel 1 rises: irq one cycle after its pending flag.
      async_in[1] = 1'b1;
      step(STB + 2);
      check("irq_evt1",    32'(evt_pending_o), 32'h2);
      check("irq_lag",     32'(irq_o), 32'h0);
      step(1);
      check("irq_set",     32'(irq_o), 32'h1);
      evt_clr_i = 4'b0010;
      step(1);
      evt_clr_i = '0;
      check("irq_evt_clr", 32'(evt_pending_o), 32'h0);
      check("irq_still",   32'(irq_o), 32'h1);
      step(1);
      check("irq_drop",    32'(irq_o), 32'h0);
      async_in[1] = 1'b0;
      step(STB + 4);
      evt_clr_i = 4'b0010;
      step(1);
      evt_clr_i = '0;
      step(1);
`endif

      // Reset mid-settle on channel 3 (count at 5), with channel 2 still high.
      async_in[3] = 1'b1;
      step(7);
      rst = 1'b1;
      #1;
      check("rst_level", 32'(level_o), 32'h0);
      check("rst_evt",   32'(evt_pending_o), 32'h0);
      check("rst_rise",  32'(rise_o), 32'h0);
      check("rst_irq",   32'(irq_o), 32'h0);
      step(2);
      rst = 1'b0;
      for (int c = 0; c < NCH; c++) rise_cnt[c] = 0;
      step(STB + 1);
      check("rerun_rise_before", 32'(rise_o), 32'h0);
      step(1);
      check("rerun_rise",  32'(rise_o), 32'hC);
      check("rerun_level", 32'(level_o), 32'hC);
      check("rerun_evt",   32'(evt_pending_o), 32'hC);
      step(3);
      check("rerun_one_rise3", 32'(rise_cnt[3]), 32'h1);
      check("final_irq",       32'(irq_o), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
